// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/hold handling and saturating bubble/flush performance counters.
module id_ex_stage_reg #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_r1,
   input  logic [REG_W-1:0]  id_r2,
   input  logic              id_uses_r1,
   input  logic              id_uses_r2,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [DATA_W-1:0] id_rd1_data,
   input  logic [DATA_W-1:0] id_rd2_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              id_alu_src,
   input  logic [2:0]        id_alu_op,
   input  logic              flush,
   input  logic              hold,
   output logic              stall,
   output logic              ex_valid,
   output logic [REG_W-1:0]  ex_r1,
   output logic [REG_W-1:0]  ex_r2,
   output logic [REG_W-1:0]  ex_rd,
   output logic [DATA_W-1:0] ex_rd1_data,
   output logic [DATA_W-1:0] ex_rd2_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              ex_alu_src,
   output logic [2:0]        ex_alu_op,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              r_valid;
   logic [REG_W-1:0]  r_r1, r_r2, r_rd;
   logic [DATA_W-1:0] r_rd1_data, r_rd2_data, r_imm;
   logic [4:0]        r_ctl;
   logic [2:0]        r_alu_op;
   logic [CNT_W-1:0]  r_bubble_cnt, r_flush_cnt;

   logic w_load_use;
   logic w_ctl_keep;

   // A load in EX whose destination feeds a source the ID instruction reads.
   assign w_load_use = id_valid & r_valid & r_ctl[3] &
                       ((id_uses_r1 & (id_r1 == r_rd)) |
                        (id_uses_r2 & (id_r2 == r_rd)));

   assign stall      = ~rst & (hold | (w_load_use & ~flush));
   assign w_ctl_keep = id_valid & ~flush & ~w_load_use;

   // Index/data fields always follow ID; only valid and control are killed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_r1         <= '0;
         r_r2         <= '0;
         r_rd         <= '0;
         r_rd1_data   <= '0;
         r_rd2_data   <= '0;
         r_imm        <= '0;
         r_ctl        <= '0;
         r_alu_op     <= '0;
         r_bubble_cnt <= '0;
         r_flush_cnt  <= '0;
      end else if (!hold) begin
         r_r1       <= id_r1;
         r_r2       <= id_r2;
         r_rd       <= id_rd;
         r_rd1_data <= id_rd1_data;
         r_rd2_data <= id_rd2_data;
         r_imm      <= id_imm;
         r_valid    <= w_ctl_keep;
         r_ctl      <= w_ctl_keep ? {id_reg_write, id_mem_read, id_mem_write,
                                     id_mem_to_reg, id_alu_src} : 5'b0;
         r_alu_op   <= w_ctl_keep ? id_alu_op : 3'b0;
         if (flush) begin
            if (r_flush_cnt != '1)
               r_flush_cnt <= r_flush_cnt + CNT_ONE;
         end else if (w_load_use) begin
            if (r_bubble_cnt != '1)
               r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
         end
      end
   end

   assign ex_valid      = r_valid;
   assign ex_r1         = r_r1;
   assign ex_r2         = r_r2;
   assign ex_rd         = r_rd;
   assign ex_rd1_data   = r_rd1_data;
   assign ex_rd2_data   = r_rd2_data;
   assign ex_imm        = r_imm;
   assign ex_reg_write  = r_ctl[4];
   assign ex_mem_read   = r_ctl[3];
   assign ex_mem_write  = r_ctl[2];
   assign ex_mem_to_reg = r_ctl[1];
   assign ex_alu_src    = r_ctl[0];
   assign ex_alu_op     = r_alu_op;
   assign bubble_cnt    = r_bubble_cnt;
   assign flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed vector bench for id_ex_stage_reg: reset, pass-through, load-use
// bubbles, flush/hold priority, reset mid-hazard and counter saturation.
module tb_id_ex_stage_reg;

   localparam int DATA_W = 16;
   localparam int REG_W  = 3;
   // Narrow counters so saturation is reachable in a few hundred cycles.
   localparam int CNT_W  = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              clk = 1'b0;
   logic              rst, id_valid, id_uses_r1, id_uses_r2;
   logic [REG_W-1:0]  id_r1, id_r2, id_rd;
   logic [DATA_W-1:0] id_rd1_data, id_rd2_data, id_imm;
   logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
   logic [2:0]        id_alu_op;
   logic              flush, hold, stall, ex_valid;
   logic [REG_W-1:0]  ex_r1, ex_r2, ex_rd;
   logic [DATA_W-1:0] ex_rd1_data, ex_rd2_data, ex_imm;
   logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
   logic [2:0]        ex_alu_op;
   logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

   int checks   = 0;
   int failures = 0;

   id_ex_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_r1(id_r1), .id_r2(id_r2), .id_uses_r1(id_uses_r1), .id_uses_r2(id_uses_r2),
      .id_rd(id_rd), .id_rd1_data(id_rd1_data), .id_rd2_data(id_rd2_data), .id_imm(id_imm),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
      .flush(flush), .hold(hold), .stall(stall), .ex_valid(ex_valid),
      .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_rd(ex_rd),
      .ex_rd1_data(ex_rd1_data), .ex_rd2_data(ex_rd2_data), .ex_imm(ex_imm),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
      .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // ctl packs {reg_write, mem_read, mem_write, mem_to_reg, alu_src}.
   typedef struct {
      logic              rst, hold, flush, valid, u1, u2;
      logic [REG_W-1:0]  r1, r2, rd;
      logic [DATA_W-1:0] d1, d2, imm;
      logic [4:0]        ctl;
      logic [2:0]        op;
      logic              eStall, eValid;
      logic [4:0]        eCtl;
      logic [2:0]        eOp;
      logic [CNT_W-1:0]  eBub, eFl;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input logic rs, ho, fl, va, u1, u2,
                         input logic [REG_W-1:0] r1, r2, rd,
                         input logic [DATA_W-1:0] d1, d2, imm,
                         input logic [4:0] ctl, input logic [2:0] op,
                         input logic eStall, eValid, input logic [4:0] eCtl,
                         input logic [2:0] eOp, input logic [CNT_W-1:0] eBub, eFl);
      vec_t v;
      v.rst = rs; v.hold = ho; v.flush = fl; v.valid = va; v.u1 = u1; v.u2 = u2;
      v.r1 = r1; v.r2 = r2; v.rd = rd; v.d1 = d1; v.d2 = d2; v.imm = imm;
      v.ctl = ctl; v.op = op;
      v.eStall = eStall; v.eValid = eValid; v.eCtl = eCtl; v.eOp = eOp;
      v.eBub = eBub; v.eFl = eFl;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      rst = v.rst; hold = v.hold; flush = v.flush;
      id_valid = v.valid; id_uses_r1 = v.u1; id_uses_r2 = v.u2;
      id_r1 = v.r1; id_r2 = v.r2; id_rd = v.rd;
      id_rd1_data = v.d1; id_rd2_data = v.d2; id_imm = v.imm;
      {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src} = v.ctl;
      id_alu_op = v.op;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Builds a plain ID instruction for the hand-written sequences.
   function automatic vec_t mkIn(input logic fl, va, u1, u2,
                                 input logic [REG_W-1:0] r1, r2, rd,
                                 input logic [4:0] ctl);
      vec_t v;
      v = '{default: '0};
      v.flush = fl; v.valid = va; v.u1 = u1; v.u2 = u2;
      v.r1 = r1; v.r2 = r2; v.rd = rd; v.ctl = ctl;
      v.d1 = 16'h0011; v.d2 = 16'h0022; v.imm = 16'h0033;
      return v;
   endfunction

   task automatic stepCycle(input vec_t v);
      applyStimulus(v);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [REG_W-1:0]  expR1, expR2, expRd;
      logic [DATA_W-1:0] expD1, expD2, expImm;
      vec_t v;
      logic stallSeen;
      expR1 = '0; expR2 = '0; expRd = '0; expD1 = '0; expD2 = '0; expImm = '0;

      //      rst ho fl va u1 u2 r1 r2 rd  d1       d2       imm      ctl       op  | stall val eCtl    eOp bub fl
      addVec(1, 1, 1, 1, 1, 1, 7, 7, 7, 16'h5A5A, 16'hA5A5, 16'h0F0F, 5'b11111, 7,  0, 0, 5'b00000, 0, 0, 0);
      addVec(1, 0, 0, 1, 1, 1, 1, 2, 3, 16'h1111, 16'h2222, 16'h3333, 5'b11111, 5,  0, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 1, 1, 1, 2, 3, 5, 16'h1234, 16'hABCD, 16'hFFF0, 5'b10000, 3,  0, 1, 5'b10000, 3, 0, 0);
      addVec(0, 0, 0, 1, 1, 0, 1, 0, 4, 16'h0001, 16'h0002, 16'h0004, 5'b11010, 0,  0, 1, 5'b11010, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 1, 7, 4, 6, 16'h0010, 16'h0020, 16'h0030, 5'b10000, 1,  1, 0, 5'b00000, 0, 1, 0);
      addVec(0, 0, 0, 1, 0, 1, 7, 4, 6, 16'h0010, 16'h0020, 16'h0030, 5'b10000, 1,  0, 1, 5'b10000, 1, 1, 0);
      addVec(0, 0, 0, 1, 1, 0, 5, 0, 4, 16'h0040, 16'h0050, 16'h0060, 5'b11010, 0,  0, 1, 5'b11010, 0, 1, 0);
      addVec(0, 0, 0, 1, 0, 0, 4, 4, 6, 16'h0070, 16'h0080, 16'h0090, 5'b10000, 1,  0, 1, 5'b10000, 1, 1, 0);
      addVec(0, 0, 0, 1, 0, 0, 0, 0, 6, 16'h00A0, 16'h00B0, 16'h00C0, 5'b11010, 0,  0, 1, 5'b11010, 0, 1, 0);
      addVec(0, 0, 0, 1, 1, 1, 4, 4, 2, 16'h00D0, 16'h00E0, 16'h00F0, 5'b10001, 2,  0, 1, 5'b10001, 2, 1, 0);
      addVec(0, 0, 0, 1, 0, 0, 3, 3, 0, 16'h0100, 16'h0200, 16'h0300, 5'b11010, 0,  0, 1, 5'b11010, 0, 1, 0);
      addVec(0, 0, 0, 1, 1, 0, 0, 5, 7, 16'h0400, 16'h0500, 16'h0600, 5'b10000, 4,  1, 0, 5'b00000, 0, 2, 0);
      addVec(0, 0, 0, 1, 0, 0, 1, 1, 3, 16'h0700, 16'h0800, 16'h0900, 5'b11010, 0,  0, 1, 5'b11010, 0, 2, 0);
      addVec(0, 0, 1, 1, 0, 1, 2, 3, 5, 16'h0A00, 16'h0B00, 16'h0C00, 5'b10000, 6,  0, 0, 5'b00000, 0, 2, 1);
      addVec(0, 0, 0, 0, 1, 1, 3, 3, 3, 16'h0D00, 16'h0E00, 16'h0F00, 5'b11111, 0,  0, 0, 5'b00000, 0, 2, 1);
      addVec(0, 0, 0, 1, 0, 0, 6, 6, 2, 16'h1000, 16'h2000, 16'h3000, 5'b11010, 0,  0, 1, 5'b11010, 0, 2, 1);
      addVec(0, 1, 0, 1, 1, 0, 2, 0, 7, 16'h4000, 16'h5000, 16'h6000, 5'b10000, 1,  1, 1, 5'b11010, 0, 2, 1);
      addVec(0, 1, 0, 0, 0, 0, 1, 1, 1, 16'h7000, 16'h8000, 16'h9000, 5'b00000, 0,  1, 1, 5'b11010, 0, 2, 1);
      addVec(0, 1, 1, 1, 1, 0, 2, 0, 7, 16'h4000, 16'h5000, 16'h6000, 5'b10000, 1,  1, 1, 5'b11010, 0, 2, 1);
      addVec(0, 0, 0, 0, 1, 0, 2, 2, 2, 16'h0001, 16'h0001, 16'h0001, 5'b11010, 0,  0, 0, 5'b00000, 0, 2, 1);
      addVec(0, 0, 0, 1, 0, 0, 6, 6, 2, 16'h1000, 16'h2000, 16'h3000, 5'b11010, 0,  0, 1, 5'b11010, 0, 2, 1);
      addVec(0, 0, 0, 1, 1, 0, 2, 0, 7, 16'h4000, 16'h5000, 16'h6000, 5'b10000, 1,  1, 0, 5'b00000, 0, 3, 1);
      addVec(0, 0, 0, 1, 0, 0, 0, 0, 1, 16'h0001, 16'h0002, 16'h0003, 5'b11010, 0,  0, 1, 5'b11010, 0, 3, 1);
      addVec(1, 0, 0, 1, 0, 1, 0, 1, 2, 16'h0004, 16'h0005, 16'h0006, 5'b10000, 1,  0, 0, 5'b00000, 0, 0, 0);
      addVec(0, 0, 0, 1, 0, 0, 3, 4, 5, 16'hBEEF, 16'hCAFE, 16'h8001, 5'b00101, 7,  0, 1, 5'b00101, 7, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         #2;
         checkOutput($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].eStall));
         @(posedge clk);
         #1;
         if (vecs[i].rst) begin
            expR1 = '0; expR2 = '0; expRd = '0; expD1 = '0; expD2 = '0; expImm = '0;
         end else if (!vecs[i].hold) begin
            expR1 = vecs[i].r1; expR2 = vecs[i].r2; expRd = vecs[i].rd;
            expD1 = vecs[i].d1; expD2 = vecs[i].d2; expImm = vecs[i].imm;
         end
         checkOutput($sformatf("v%0d.valid", i), 32'(ex_valid), 32'(vecs[i].eValid));
         checkOutput($sformatf("v%0d.ctl", i),
                     32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src}),
                     32'(vecs[i].eCtl));
         checkOutput($sformatf("v%0d.alu_op", i), 32'(ex_alu_op), 32'(vecs[i].eOp));
         checkOutput($sformatf("v%0d.idx", i), 32'({ex_r1, ex_r2, ex_rd}), 32'({expR1, expR2, expRd}));
         checkOutput($sformatf("v%0d.rd1", i), 32'(ex_rd1_data), 32'(expD1));
         checkOutput($sformatf("v%0d.rd2", i), 32'(ex_rd2_data), 32'(expD2));
         checkOutput($sformatf("v%0d.imm", i), 32'(ex_imm), 32'(expImm));
         checkOutput($sformatf("v%0d.bubble_cnt", i), 32'(bubble_cnt), 32'(vecs[i].eBub));
         checkOutput($sformatf("v%0d.flush_cnt", i), 32'(flush_cnt), 32'(vecs[i].eFl));
      end

      // Drive bubble_cnt to its ceiling with alternating load / dependent pairs.
      stallSeen = 1'b1;
      for (int n = 0; n < 255; n++) begin
         stepCycle(mkIn(0, 1, 1, 0, 1, 0, 4, 5'b11010));
         applyStimulus(mkIn(0, 1, 0, 1, 0, 4, 6, 5'b10000));
         #2;
         stallSeen = stallSeen & stall;
         @(posedge clk);
         #1;
      end
      checkOutput("sat.stall_every_pair", 32'(stallSeen), 32'(1));
      checkOutput("sat.bubble_at_max", 32'(bubble_cnt), 32'(CNT_MAX));
      stepCycle(mkIn(0, 1, 1, 0, 1, 0, 4, 5'b11010));
      applyStimulus(mkIn(0, 1, 0, 1, 0, 4, 6, 5'b10000));
      #2;
      checkOutput("sat.extra_stall", 32'(stall), 32'(1));
      @(posedge clk);
      #1;
      checkOutput("sat.extra_bubble_valid", 32'(ex_valid), 32'(0));
      checkOutput("sat.bubble_no_wrap", 32'(bubble_cnt), 32'(CNT_MAX));

      // Same ceiling for flush_cnt; bubble_cnt must not move meanwhile.
      for (int n = 0; n < 254; n++)
         stepCycle(mkIn(1, 1, 0, 0, 0, 0, 1, 5'b10000));
      checkOutput("sat.flush_below_max", 32'(flush_cnt), 32'(CNT_MAX - 8'd1));
      stepCycle(mkIn(1, 1, 0, 0, 0, 0, 1, 5'b10000));
      checkOutput("sat.flush_at_max", 32'(flush_cnt), 32'(CNT_MAX));
      stepCycle(mkIn(1, 1, 0, 0, 0, 0, 1, 5'b10000));
      checkOutput("sat.flush_no_wrap", 32'(flush_cnt), 32'(CNT_MAX));
      checkOutput("sat.bubble_untouched", 32'(bubble_cnt), 32'(CNT_MAX));

      v = mkIn(0, 0, 0, 0, 0, 0, 0, 5'b00000);
      v.rst = 1'b1;
      stepCycle(v);
      checkOutput("final.reset_counters", 32'({bubble_cnt, flush_cnt}), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between ID and EX.
- Captures the decoded instruction: source/destination indices, operand data, immediate, control bits.
- Presents these to the EX stage and to the forwarding unit.
- Detects load-use hazards against the instruction currently in EX, requests an IF/ID stall and inserts a bubble. Applies branch flushes and external holds. Counts inserted bubbles and flushes for performance observation.

Parameters:
- DATA_W, 16, width of register-file operands and immediate
- REG_W, 3, width of register indices (8 architectural registers)
- CNT_W, 16, width of bubble/flush performance counters

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_r1, id_r2  in  REG_W  source register indices
- id_uses_r1, id_uses_r2  in  1  instruction actually reads r1 / r2
- id_rd  in  REG_W  destination register index
- id_rd1_data, id_rd2_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  in  1  control bits
- id_alu_op  in  3  ALU operation
- flush  in  1  branch resolved taken in EX; kill the instruction in ID
- hold  in  1  external stall (memory busy); freeze this register
- stall  out  1  combinational; freeze PC and IF/ID this cycle
- ex_valid  out  1  registered valid
- ex_r1, ex_r2, ex_rd  out  REG_W  registered indices; ex_r1/ex_r2 drive the forwarding unit's source inputs
- ex_rd1_data, ex_rd2_data, ex_imm  out  DATA_W  registered data
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1  registered control
- ex_alu_op  out  3  registered ALU op
- bubble_cnt, flush_cnt  out  CNT_W  saturating performance counters

Behaviour:
- Reset: all ex_* outputs and both counters are 0. stall is 0 while rst is high.
- Load-use detection (combinational):
  - load_use = id_valid & ex_valid & ex_mem_read & ((id_uses_r1 & id_r1==ex_rd) | (id_uses_r2 & id_r2==ex_rd)).
  - Index 0 is not special; it is compared like any other index.
- stall = hold | (load_use & ~flush).
- Per-edge priority, highest first:
  1. rst: clear everything.
  2. hold: all registers, including counters, keep their values.
  3. flush: ex_valid and all ex_* control bits and ex_alu_op become 0. Index and data fields load from id_* normally. flush_cnt increments.
  4. load_use: bubble, with control cleared exactly as for flush. Index and data fields load normally. bubble_cnt increments. The same ID instruction re-presents next cycle because IF/ID is stalled.
  5. Otherwise: all ex_* load from id_*. ex_valid = id_valid. If id_valid=0, control bits load as 0 regardless of id_* control.
- Latency: one cycle, ID inputs to ex_* outputs.
- A bubble lasts exactly one cycle. After it, ex_mem_read=0, so load_use clears and the stalled instruction enters EX on the next edge. In that cycle the forwarding unit resolves the value from the load's MEM/WB stage.
- Counters saturate at 2^CNT_W-1 with no wrap. They increment only on the edge where the corresponding event is taken under the priority above.
- flush and load_use in the same cycle: flush wins, stall=0, flush_cnt increments, bubble_cnt does not.
- hold together with any other event: hold wins, and stall=1.
- rst asserted mid-bubble or mid-hold: next edge clears everything; no stall persists.

Test Plan:
- Reset: rst=1 for 2 cycles with random id_* -> all ex_* = 0, bubble_cnt=flush_cnt=0, stall=0.
- Pass-through: id_valid=1, r1=2, r2=3, rd=5, rd1=0x1234, rd2=0xABCD, imm=0xFFF0, reg_write=1, alu_op=3 -> next cycle ex_* match exactly, ex_valid=1, stall=0.
- Load-use:
  - Setup: EX holds a load (ex_mem_read=1, ex_rd=4); ID instruction has uses_r2=1, r2=4.
  - Detect cycle: stall=1.
  - Next edge: ex_valid=0, ex_reg_write=0, bubble_cnt=1.
  - Following edge: the dependent instruction loads, stall=0.
- No false hazard: same setup as load-use, but uses_r2=0 (or ex_mem_read=0, or ex_rd=6) -> stall=0, no bubble.
- Flush vs load-use: load_use condition true and flush=1 in the same cycle -> stall=0, ex_valid=0, flush_cnt=1, bubble_cnt=0.
- Hold and saturation:
  - hold=1 for 3 cycles with changing id_* -> ex_* and counters frozen, stall=1.
  - Preload bubble_cnt to 0xFFFF via repeated load-use -> a further bubble leaves it 0xFFFF.
